// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared constants, state encoding and PC helpers for the fetch sequencer.
package pc_fetch_sequencer_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int          INSTR_BYTES      = 2;
    // Opcode the decoder matches to raise halt_detect.
    localparam logic [3:0]  HLT_OPCODE       = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    function automatic logic [15:0] align_pc(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side signal bundle: branch redirect, decode stall, imem handshake, IF/ID handoff.
// Statistics counters are present only when PC_SEQ_STATS_EN is defined.
interface pc_fetch_sequencer_if #(
    parameter int STAT_W = 16
);
    logic        stall_i;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_ready;
    logic        halt_detect;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;

`ifdef PC_SEQ_STATS_EN
    logic [STAT_W-1:0] stat_redirects;
    logic [STAT_W-1:0] stat_wait_cycles;

    modport master (
        input  stall_i, redirect_valid, redirect_pc, imem_ready, halt_detect,
        output imem_req, imem_addr, if_valid, if_pc, if_pc_plus2, halted,
        output stat_redirects, stat_wait_cycles
    );
    modport slave (
        output stall_i, redirect_valid, redirect_pc, imem_ready, halt_detect,
        input  imem_req, imem_addr, if_valid, if_pc, if_pc_plus2, halted,
        input  stat_redirects, stat_wait_cycles
    );
`else
    localparam int STAT_W_UNUSED = STAT_W;

    modport master (
        input  stall_i, redirect_valid, redirect_pc, imem_ready, halt_detect,
        output imem_req, imem_addr, if_valid, if_pc, if_pc_plus2, halted
    );
    modport slave (
        output stall_i, redirect_valid, redirect_pc, imem_ready, halt_detect,
        input  imem_req, imem_addr, if_valid, if_pc, if_pc_plus2, halted
    );
`endif

endinterface

// File: rtl/pc_fetch_sequencer_adder.sv
// 16-bit add/subtract (Adder_16bit datapath): sum = a +/- b, signed overflow flag.
// Latency: combinational.
// Backpressure: none.
module pc_fetch_sequencer_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        ovf
);
    logic [15:0] b_eff;

    always_comb begin
        b_eff = b ^ {16{sub}};
        sum   = a + b_eff + {15'd0, sub};
        ovf   = (a[15] == b_eff[15]) && (sum[15] != a[15]);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register and fetch sequencer: redirects, decode stalls, multi-cycle imem, HLT. Optional PC_SEQ_STATS_EN counters.
// Latency: redirect -> imem_addr next cycle (or the cycle after imem_ready when pended); 1 instr/cycle streaming.
// Backpressure: imem_ready low parks in WAIT; stall_i refetches the same PC; HALTED drops imem_req until rst.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          STAT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    pc_fetch_sequencer_if.master bus
);
    seq_state_t  state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [15:0] pend_pc, pend_pc_nxt;
    logic [15:0] pc_plus2;
    logic        add_ovf_unused;
    logic        redirect_taken;
    logic [15:0] redirect_tgt;

    pc_fetch_sequencer_adder u_pc_inc (
        .a   (pc),
        .b   (16'(INSTR_BYTES)),
        .sub (1'b0),
        .sum (pc_plus2),
        .ovf (add_ovf_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= align_pc(RESET_PC);
            pend_valid <= 1'b0;
            pend_pc    <= 16'h0000;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        redirect_taken = 1'b0;
        redirect_tgt   = align_pc(bus.redirect_pc);
        if (state != ST_HALTED) begin
            if (bus.redirect_valid && (state == ST_FETCH || bus.imem_ready)) begin
                redirect_taken = 1'b1;
                pc_nxt         = redirect_tgt;
                pend_valid_nxt = 1'b0;
                state_nxt      = ST_FETCH;
            end else if (bus.redirect_valid) begin
                // Memory still owes us the wrong-path word; park the target until it lands.
                redirect_taken = 1'b1;
                pend_pc_nxt    = redirect_tgt;
                pend_valid_nxt = 1'b1;
                state_nxt      = ST_WAIT;
            end else if (!bus.imem_ready) begin
                state_nxt = ST_WAIT;
            end else if (pend_valid) begin
                pc_nxt         = pend_pc;
                pend_valid_nxt = 1'b0;
                state_nxt      = ST_FETCH;
            end else if (bus.stall_i) begin
                state_nxt = ST_FETCH;
            end else if (bus.halt_detect) begin
                state_nxt = ST_HALTED;
            end else begin
                pc_nxt    = pc_plus2;
                state_nxt = ST_FETCH;
            end
        end
    end

    always_comb begin
        bus.imem_req    = (state != ST_HALTED) && !rst;
        bus.imem_addr   = pc;
        bus.if_pc       = pc;
        bus.if_pc_plus2 = pc_plus2;
        bus.halted      = (state == ST_HALTED) && !rst;
        bus.if_valid    = !rst && (state != ST_HALTED) && bus.imem_ready &&
                          !bus.redirect_valid && !pend_valid && !bus.stall_i;
    end

`ifdef PC_SEQ_STATS_EN
    logic [STAT_W-1:0] stat_redirects_q;
    logic [STAT_W-1:0] stat_wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_redirects_q <= '0;
            stat_wait_q      <= '0;
        end else if (state != ST_HALTED) begin
            if (redirect_taken && !(&stat_redirects_q))
                stat_redirects_q <= stat_redirects_q + 1'b1;
            if (state == ST_WAIT && !(&stat_wait_q))
                stat_wait_q <= stat_wait_q + 1'b1;
        end
    end

    always_comb begin
        bus.stat_redirects   = stat_redirects_q;
        bus.stat_wait_cycles = stat_wait_q;
    end
`else
    localparam int STAT_W_UNUSED = STAT_W;
    logic redirect_taken_unused;
    always_comb redirect_taken_unused = redirect_taken;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed vector table, PC_SEQ_STATS_EN counter sequence, randomized run vs. reference model.
module tb_pc_fetch_sequencer;

    localparam int TB_STAT_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pc_fetch_sequencer_if #(.STAT_W(TB_STAT_W)) bus ();

    pc_fetch_sequencer #(
        .RESET_PC (16'h0000),
        .STAT_W   (TB_STAT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic        hlt;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_vld;
        logic        exp_halted;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: fetch address, outstanding-miss flag, parked redirect, halt latch.
    int  m_pc;
    bit  m_missing;
    int  m_pend[$];
    bit  m_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic rv, input logic [15:0] rp,
                         input logic rdy, input logic hd);
        @(negedge clk);
        rst                = r;
        bus.stall_i        = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.imem_ready     = rdy;
        bus.halt_detect    = hd;
        #2;
    endtask

    task automatic add(input logic r, input logic st, input logic rv, input logic [15:0] rp,
                       input logic rdy, input logic hd, input logic req, input logic [15:0] addr,
                       input logic vld, input logic hltd);
        vec_t v;
        v.rst = r; v.stall = st; v.rv = rv; v.rpc = rp; v.rdy = rdy; v.hlt = hd;
        v.exp_req = req; v.exp_addr = addr; v.exp_vld = vld; v.exp_halted = hltd;
        tbl.push_back(v);
    endtask

    task automatic model_step(input logic r, input logic st, input logic rv, input logic [15:0] rp,
                              input logic rdy, input logic hd);
        if (r) begin
            m_pc = 0; m_missing = 0; m_pend.delete(); m_halted = 0;
        end else if (m_halted) begin
        end else if (rv) begin
            if (!m_missing || rdy) begin
                m_pc = int'(rp) & 32'hFFFE; m_pend.delete(); m_missing = 0;
            end else begin
                m_pend.delete();
                m_pend.push_back(int'(rp) & 32'hFFFE);
            end
        end else if (!rdy) begin
            m_missing = 1;
        end else begin
            m_missing = 0;
            if (m_pend.size() > 0) m_pc = m_pend.pop_front();
            else if (st) ;
            else if (hd) m_halted = 1;
            else m_pc = (m_pc + 2) % 65536;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.stall_i = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.imem_ready = 0; bus.halt_detect = 0;
        repeat (2) @(posedge clk);

        //   rst st rv rpc      rdy hd | req addr     vld hltd
        add(1, 0, 0, 16'h0000, 1, 0,   0, 16'h0000, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0000, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0002, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0004, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0006, 1, 0);
        add(0, 0, 1, 16'h0010, 1, 0,   1, 16'h0008, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0,   1, 16'h0010, 0, 0);
        add(0, 0, 1, 16'h0041, 0, 0,   1, 16'h0010, 0, 0);
        add(0, 1, 0, 16'h0000, 0, 0,   1, 16'h0010, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0010, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0040, 1, 0);
        add(0, 0, 1, 16'h0021, 1, 0,   1, 16'h0042, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 0,   1, 16'h0020, 0, 0);
        add(0, 1, 0, 16'h0000, 1, 0,   1, 16'h0020, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0020, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0022, 1, 0);
        add(0, 0, 1, 16'h0030, 0, 0,   1, 16'h0024, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 1,   1, 16'h0030, 1, 0);
        add(0, 0, 1, 16'h0100, 1, 0,   0, 16'h0030, 0, 1);
        add(0, 1, 0, 16'h0000, 1, 1,   0, 16'h0030, 0, 1);
        add(1, 0, 0, 16'h0000, 1, 0,   0, 16'h0030, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0000, 1, 0);
        add(0, 0, 1, 16'hFFFF, 1, 0,   1, 16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'hFFFE, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0000, 1, 0);
        add(0, 0, 0, 16'h0000, 0, 0,   1, 16'h0002, 0, 0);
        add(0, 0, 1, 16'h0200, 0, 0,   1, 16'h0002, 0, 0);
        add(1, 0, 0, 16'h0000, 1, 0,   0, 16'h0002, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0,   1, 16'h0000, 1, 0);

        foreach (tbl[i]) begin
            logic [15:0] exp_p2;
            exp_p2 = tbl[i].exp_addr + 16'd2;
            drive(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].hlt);
            chk($sformatf("vec%0d imem_req", i),    32'(bus.imem_req),    32'(tbl[i].exp_req));
            chk($sformatf("vec%0d imem_addr", i),   32'(bus.imem_addr),   32'(tbl[i].exp_addr));
            chk($sformatf("vec%0d if_pc", i),       32'(bus.if_pc),       32'(tbl[i].exp_addr));
            chk($sformatf("vec%0d if_valid", i),    32'(bus.if_valid),    32'(tbl[i].exp_vld));
            chk($sformatf("vec%0d halted", i),      32'(bus.halted),      32'(tbl[i].exp_halted));
            chk($sformatf("vec%0d if_pc_plus2", i), 32'(bus.if_pc_plus2), 32'(exp_p2));
        end

`ifdef PC_SEQ_STATS_EN
        drive(1, 0, 0, 16'h0000, 0, 0);
        chk("stat_redirects reset", 32'(bus.stat_redirects), 32'd0);
        drive(0, 0, 1, 16'h0010, 1, 0);
        drive(0, 0, 0, 16'h0000, 0, 0);
        drive(0, 0, 1, 16'h0080, 0, 0);
        repeat (3) drive(0, 0, 0, 16'h0000, 0, 0);
        drive(0, 0, 0, 16'h0000, 1, 0);
        drive(0, 0, 0, 16'h0000, 1, 0);
        chk("stat_redirects count", 32'(bus.stat_redirects),   32'd2);
        chk("stat_wait_cycles count", 32'(bus.stat_wait_cycles), 32'd5);
        chk("stats pended target", 32'(bus.imem_addr), 32'h0080);
        repeat (22) drive(0, 0, 0, 16'h0000, 0, 0);
        chk("stat_wait_cycles saturate", 32'(bus.stat_wait_cycles), 32'((1 << TB_STAT_W) - 1));
`endif

        drive(1, 0, 0, 16'h0000, 0, 0);
        model_step(1, 0, 0, 16'h0000, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic r, st, rv, rdy, hd;
            logic [15:0] rp;
            logic [15:0] e_addr;
            logic        e_req, e_vld, e_h;
            r   = ($urandom_range(0, 59) == 0);
            st  = ($urandom_range(0, 5) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rp  = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            hd  = ($urandom_range(0, 39) == 0);
            drive(r, st, rv, rp, rdy, hd);
            e_addr = 16'(m_pc);
            e_req  = !r && !m_halted;
            e_h    = !r && m_halted;
            e_vld  = e_req && rdy && !rv && (m_pend.size() == 0) && !st;
            chk("rand imem_req",    32'(bus.imem_req),    32'(e_req));
            chk("rand imem_addr",   32'(bus.imem_addr),   32'(e_addr));
            chk("rand if_valid",    32'(bus.if_valid),    32'(e_vld));
            chk("rand halted",      32'(bus.halted),      32'(e_h));
            chk("rand if_pc_plus2", 32'(bus.if_pc_plus2), (32'(m_pc) + 32'd2) % 32'd65536);
            model_step(r, st, rv, rp, rdy, hd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the 16-bit pipelined core.
- Issues fetch requests to instruction memory and tolerates multi-cycle memory (ready/not-ready).
- Applies decode stalls and branch redirects resolved by the branch unit (B/BR target selection stays in PC_Control).
- Enters and holds the halted state on HLT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
STAT_W, 16, width of statistics counters (used only with PC_SEQ_STATS_EN).

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  decode hazard stall; hold current fetch
redirect_valid  input  1  branch/BR taken, resolved this cycle
redirect_pc  input  16  redirect target; bit 0 ignored (forced 0)
imem_ready  input  1  instruction at imem_addr is available this cycle
halt_detect  input  1  instruction returned this cycle is HLT (qualified by imem_ready)
imem_req  output  1  fetch request for imem_addr
imem_addr  output  16  fetch address (= PC register)
if_valid  output  1  returned instruction is accepted into IF/ID this cycle
if_pc  output  16  PC of the accepted instruction (= PC register)
if_pc_plus2  output  16  if_pc + 2, mod 2^16 (for PCS / link)
halted  output  1  processor halted

Behaviour:
- Single clock clk; rst is synchronous, active-high. Reset is sampled on the rising edge and overrides all other inputs.
- State: FETCH, WAIT (memory not ready), HALTED. Registers: pc, pend_valid, pend_pc.
- Reset values:
  - pc = RESET_PC; state FETCH; pend_valid = 0; pend_pc = 0.
  - While rst is high: imem_req = 0, if_valid = 0, halted = 0.
- Outputs are combinational from the registers and current inputs:
  - imem_req = (state != HALTED) & !rst.
  - imem_addr = if_pc = pc.
  - if_pc_plus2 = pc + 2, wrapping 0xFFFE -> 0x0000 with no overflow indication.
  - halted = (state == HALTED).
- Per-cycle priority, state FETCH or WAIT:
  1. redirect_valid & (state == FETCH | imem_ready): pc <= {redirect_pc[15:1], 0}; pend_valid <= 0; state <= FETCH; if_valid = 0 (wrong-path instruction dropped).
  2. redirect_valid & state == WAIT & !imem_ready: pend_pc <= {redirect_pc[15:1], 0}; pend_valid <= 1; state stays WAIT; pc holds. A later redirect before memory returns overwrites pend_pc.
  3. imem_ready & pend_valid: if_valid = 0; pc <= pend_pc; pend_valid <= 0; state <= FETCH.
  4. imem_ready & stall_i: if_valid = 0; pc holds; state FETCH (same address refetched next cycle).
  5. imem_ready & !stall_i & halt_detect: if_valid = 1 (HLT flows down the pipe); pc holds; state <= HALTED.
  6. imem_ready & !stall_i: if_valid = 1; pc <= pc + 2 (wraps); state FETCH.
  7. !imem_ready: if_valid = 0; pc holds; state <= WAIT. stall_i has no effect while waiting.
- HALTED: all inputs except rst ignored (including redirect_valid); pc frozen at the HLT address; if_valid = 0. Exit only via rst.
- Latency:
  - Redirect in cycle n gives imem_addr = target in cycle n+1 (or the cycle after imem_ready if pended).
  - Sequential fetch gives one instruction per cycle when imem_ready is held high.
- Reset mid-WAIT or mid-pend discards the pending target; next cycle fetches RESET_PC.

Optional Feature:
- Macro PC_SEQ_STATS_EN.
- Defined:
  - Adds outputs stat_redirects[STAT_W-1:0] (increments on every accepted redirect, i.e. rules 1 and 2).
  - Adds stat_wait_cycles[STAT_W-1:0] (increments each cycle in WAIT).
  - Both counters saturate at all-ones, reset to 0, and freeze in HALTED.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: RESET_PC default, INSTR_BYTES = 2, and the state encoding (FETCH=2'd0, WAIT=2'd1, HALTED=2'd2).
- Package also holds the HLT opcode constant used by the decoder that drives halt_detect.
- The PC increment reuses the existing Adder_16bit (A = pc, B = 16'h0002, Sub = 0; overflow unused).
- No other sub-module: the FSM stays inline.

Test Plan:
- Reset then imem_ready held 1 for 4 cycles -> imem_addr 0x0000, 0x0002, 0x0004, 0x0006; if_valid = 1 each cycle; if_pc_plus2 = if_pc + 2.
- imem_ready low 3 cycles at pc = 0x0010, with redirect_valid / redirect_pc = 0x0041 in the 2nd cycle:
  - while waiting: pc stays 0x0010;
  - on ready: if_valid = 0;
  - next cycle: imem_addr = 0x0040.
- stall_i = 1 for 2 cycles at pc = 0x0020 with imem_ready = 1 -> if_valid = 0 and imem_addr = 0x0020 both cycles; after release, if_valid = 1 at 0x0020, then 0x0022.
- HLT returned at pc = 0x0030:
  - that cycle: if_valid = 1;
  - thereafter: halted = 1, imem_req = 0, pc = 0x0030;
  - redirect_valid asserted while halted is ignored;
  - rst -> pc = 0x0000, halted = 0.
- pc = 0xFFFE with imem_ready = 1 -> next imem_addr = 0x0000; if_pc_plus2 at 0xFFFE reads 0x0000.
- With PC_SEQ_STATS_EN: 2 redirects plus 5 WAIT cycles -> stat_redirects = 2, stat_wait_cycles = 5; force the counter to all-ones and confirm it saturates.
